// File: rtl/mix_columns_seq.sv
// mix_columns_seq
//   Iterative AES MixColumns round stage sitting between ShiftRows and
//   AddRoundKey. A single GF(2^8) column multiplier processes one 32-bit
//   column per clock, so a normal round takes NCOL cycles in BUSY. The final
//   AES round (in_last=1) bypasses the transform and completes immediately.
//
//   Optional build macro: MIX_COLUMNS_INV_EN
//     When defined, adds port in_inv. A captured in_inv=1 selects
//     InvMixColumns (coefficients 0e,0b,0d,09) instead of the forward
//     transform. Latency and bypass behaviour are unchanged.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_state   128-bit shifted state; byte 0 is the most significant byte,
//              column c = bytes 4c..4c+3 with row 0 first
//   in_valid   in_state / in_last (/ in_inv) are valid
//   in_ready   block accepts an input this cycle (combinational)
//   in_last    final round: pass the state through unchanged
//   in_inv     (MIX_COLUMNS_INV_EN only) select InvMixColumns
//   out_state  result, same byte ordering as in_state (registered)
//   out_valid  out_state holds a completed result (registered)
//   out_ready  downstream accepts out_state
module mix_columns_seq #(
    parameter int unsigned NCOL = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_state,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         in_inv,
`endif
    output logic [127:0] out_state,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned CW = (NCOL > 1) ? $clog2(NCOL) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [127:0]  work;
    logic          out_valid_q;
    logic [31:0]   cur_col;
    logic [31:0]   col_mixed;
    logic [127:0]  work_mixed;
    logic          accept;

`ifdef MIX_COLUMNS_INV_EN
    logic          inv_q;
`endif

    // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
    endfunction
`endif

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_state = work;
    assign out_valid = out_valid_q;

    // Column currently addressed by col (column 0 occupies the top 32 bits).
    always_comb begin
        cur_col = '0;
        for (int unsigned c = 0; c < NCOL; c++) begin
            if (col == CW'(c)) begin
                cur_col = work[127 - 32*c -: 32];
            end
        end
    end

    always_comb begin
`ifdef MIX_COLUMNS_INV_EN
        col_mixed = inv_q ? mix_inv(cur_col) : mix_fwd(cur_col);
`else
        col_mixed = mix_fwd(cur_col);
`endif
    end

    // Working register with only the addressed column replaced.
    always_comb begin
        work_mixed = work;
        for (int unsigned c = 0; c < NCOL; c++) begin
            if (col == CW'(c)) begin
                work_mixed[127 - 32*c -: 32] = col_mixed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            col         <= '0;
            work        <= '0;
            out_valid_q <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE with out_ready and in_valid hands off and reloads
                    // in the same edge, so back-to-back states have no bubble.
                    if (accept) begin
                        work <= in_state;
                        col  <= '0;
`ifdef MIX_COLUMNS_INV_EN
                        inv_q <= in_inv;
`endif
                        if (in_last) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state       <= BUSY;
                            out_valid_q <= 1'b0;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    work <= work_mixed;
                    if (col == CW'(NCOL - 1)) begin
                        col         <= '0;
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    col         <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

    localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
    localparam logic [127:0] R2 = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
    localparam logic [127:0] VB = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_state;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [127:0] out_state;
    logic         out_valid;
    logic         out_ready;
`ifdef MIX_COLUMNS_INV_EN
    logic         in_inv;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mix_columns_seq #(.NCOL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_state  (in_state),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
`ifdef MIX_COLUMNS_INV_EN
        .in_inv    (in_inv),
`endif
        .out_state (out_state),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Generic shift-and-add GF(2^8) multiply, then a circulant matrix product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
        logic [7:0]   co[4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inv) begin
            co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09;
        end else begin
            co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(co[(j - row + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Transaction-level model: cycles remaining until the result appears,
    // whether a result is on offer, and the value out_state must show.
    bit           started = 0;
    int           m_cnt = 0;
    bit           m_valid = 0;
    bit           m_known = 0;
    logic [127:0] m_out = '0;
    logic [127:0] m_pend = '0;

    function automatic bit m_rdy(input logic ordy);
        return (!m_valid && m_cnt == 0) || (m_valid && ordy);
    endfunction

    always @(posedge clk) begin
        bit inv;
        inv = 0;
`ifdef MIX_COLUMNS_INV_EN
        inv = in_inv;
`endif
        if (rst) begin
            started = 1;
            m_cnt   = 0;
            m_valid = 0;
            m_known = 1;
            m_out   = '0;
        end else if (started) begin
            if (in_valid && m_rdy(out_ready)) begin
                if (in_last) begin
                    m_out   = in_state;
                    m_valid = 1;
                    m_known = 1;
                    m_cnt   = 0;
                end else begin
                    m_pend  = mix_model(in_state, inv);
                    m_cnt   = 4;
                    m_valid = 0;
                    m_known = 0;
                end
            end else if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_valid = 1;
                    m_out   = m_pend;
                    m_known = 1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    // Single compare process, on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("cyc_in_ready", in_ready, m_rdy(out_ready));
            chk("cyc_out_valid", out_valid, m_valid);
            if (m_known) chk("cyc_out_state", out_state, m_out);
        end
    end

    // ---------------- stimulus helpers (drive at posedge+1) ----------------
    task automatic offer(input logic [127:0] s, input logic last);
        bit acc;
        bit ok;
        ok = 0;
        in_state = s;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1 acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) ok = 1;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int  n;
        bit  pending;
        bit  acc;
        rst       = 1'b1;
        in_state  = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
        in_inv    = 1'b0;
`endif
        chk("model_pin_fwd1", mix_model(V1, 0), R1);
        chk("model_pin_fwd2", mix_model(V2, 0), R2);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_state", out_state, '0);

        // FIPS-197 column vectors
        offer(V1, 0);
        wait_valid(n);
        chk("v1_latency", n, 4);
        chk("v1_result", out_state, R1);
        consume();
        chk("v1_consumed", out_valid, 0);

        offer(V2, 0);
        wait_valid(n);
        chk("v2_latency", n, 4);
        chk("v2_result", out_state, R2);
        consume();

        // Bypass: result already on offer right after the accept edge.
        offer(VB, 1);
        chk("bypass_valid", out_valid, 1);
        chk("bypass_result", out_state, VB);
        consume();

        // Backpressure with a competing input held on the inputs.
        offer(V1, 0);
        wait_valid(n);
        in_state = V2;
        in_last  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_state", out_state, R1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_busy_valid", out_valid, 0);
        chk("bp_busy_ready", in_ready, 0);
        wait_valid(n);
        chk("bp_next_latency", n, 4);
        chk("bp_next_result", out_state, R2);
        consume();

        // Reset while BUSY with column 2 next.
        offer(V2, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_state", out_state, '0);
        chk("midrst_in_ready", in_ready, 1);
        offer(V1, 0);
        wait_valid(n);
        chk("midrst_latency", n, 4);
        chk("midrst_result", out_state, R1);
        consume();

`ifdef MIX_COLUMNS_INV_EN
        chk("model_pin_inv", mix_model(R1, 1), V1);
        in_inv = 1'b1;
        offer(R1, 0);
        in_inv = 1'b0;
        wait_valid(n);
        chk("inv_latency", n, 4);
        chk("inv_result", out_state, V1);
        consume();
`endif

        // Randomised traffic, source holds each item until accepted.
        pending = 0;
        for (int i = 0; i < 800; i++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                pending  = 1;
                in_state = {$urandom, $urandom, $urandom, $urandom};
                in_last  = ($urandom_range(0, 3) == 0);
`ifdef MIX_COLUMNS_INV_EN
                in_inv   = $urandom_range(0, 1);
`endif
            end
            in_valid  = pending;
            out_ready = ($urandom_range(0, 9) < 7);
            #1 acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            if (acc) pending = 0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
